// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, single-outstanding imem req/ack, one-entry skid, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
`endif
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_SKID, S_DROP} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_drop_addr;
    logic                r_valid;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_ipc;
    logic [DATA_W-1:0]   r_skid_instr;
    logic [ADDR_W-1:0]   r_skid_pc;

    logic                w_slot_free;
    logic                w_hs;
    logic                w_req;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_ld_mem;
    logic                w_ld_skid;
    logic                w_from_skid;

    assign w_slot_free = !r_valid || if_ready;
    assign w_hs        = r_valid && if_ready;
    // DROP keeps presenting the abandoned address until memory acks it.
    assign w_addr      = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign imem_req  = w_req && !rst;
    assign imem_addr = w_addr;
    assign if_valid  = r_valid;
    assign if_instr  = r_instr;
    assign if_pc     = r_ipc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_ISSUE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (redirect_valid) begin
            w_next = (w_req && !imem_ack) ? S_DROP : S_ISSUE;
        end else begin
            case (r_state)
                S_ISSUE: if (w_req && !imem_ack) w_next = S_WAIT;
                S_WAIT:  if (imem_ack)           w_next = w_slot_free ? S_ISSUE : S_SKID;
                S_SKID:  if (if_ready)           w_next = S_ISSUE;
                S_DROP:  if (imem_ack)           w_next = S_ISSUE;
                default:                         w_next = S_ISSUE;
            endcase
        end
    end

    always_comb begin
        w_req       = 1'b0;
        w_ld_mem    = 1'b0;
        w_ld_skid   = 1'b0;
        w_from_skid = 1'b0;
        case (r_state)
            S_ISSUE: begin
                w_req    = w_slot_free;
                w_ld_mem = w_slot_free && imem_ack;
            end
            S_WAIT: begin
                w_req     = 1'b1;
                w_ld_mem  = imem_ack && w_slot_free;
                w_ld_skid = imem_ack && !w_slot_free;
            end
            S_SKID: w_from_skid = if_ready;
            S_DROP: w_req       = 1'b1;
            default: w_req      = 1'b0;
        endcase
        if (redirect_valid) begin
            w_ld_mem    = 1'b0;
            w_ld_skid   = 1'b0;
            w_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_drop_addr  <= '0;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_ipc        <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (redirect_valid) begin
            r_pc        <= redirect_pc;
            r_valid     <= 1'b0;
            r_drop_addr <= w_addr;
        end else begin
            if (w_ld_mem || w_ld_skid) r_pc <= r_pc + ADDR_W'(PC_STEP);
            if (w_ld_mem) begin
                r_valid <= 1'b1;
                r_instr <= imem_rdata;
                r_ipc   <= r_pc;
            end else if (w_from_skid) begin
                r_instr <= r_skid_instr;
                r_ipc   <= r_skid_pc;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_ld_skid) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (w_hs) perf_fetched <= perf_fetched + 32'd1;
            if ((imem_req && !imem_ack) || (r_state == S_SKID)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: random-latency memory, random backpressure and redirects.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_hs   = 0;
    int   mem_cnt, mem_lat;
    int   lat_max = 0;
    exp_t q_exp[$];
    logic [31:0] gen_pc;

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory: acks once the request has been held for mem_lat cycles (0 = same cycle).
    assign imem_ack   = imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt <= 0;
            mem_lat <= 0;
        end else if (imem_req && imem_ack) begin
            mem_cnt <= 0;
            mem_lat <= int'($urandom_range(lat_max, 0));
        end else if (imem_req) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference stream: program order from the current base, restarted on each redirect.
    task automatic topup();
        while (q_exp.size() < 4) begin
            exp_t e;
            e.pc    = gen_pc;
            e.instr = mem_word(gen_pc);
            q_exp.push_back(e);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] base);
        q_exp.delete();
        gen_pc = base;
        topup();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (redirect_valid) begin
            restart(redirect_pc);
            redirect_valid = 1'b0;
        end
        topup();
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            if_ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(99, 0) < 5) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            end
        end
    endtask

    // Monitor: decode-side handshakes and the memory hold-until-ack rule.
    initial begin
        logic        prev_pend = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("req_held", {63'd0, imem_req}, 64'd1);
                    chk("addr_held", {32'd0, imem_addr}, {32'd0, prev_addr});
                end
                prev_pend = imem_req && !imem_ack;
                prev_addr = imem_addr;
                if (if_valid && if_ready) begin
                    n_hs++;
                    if (q_exp.size() == 0) begin
                        chk("scoreboard_empty", 64'd0, 64'd1);
                    end else begin
                        exp_t e;
                        e = q_exp.pop_front();
                        chk("if_pc", {32'd0, if_pc}, {32'd0, e.pc});
                        chk("if_instr", {32'd0, if_instr}, {32'd0, e.instr});
                    end
                end
            end
        end
    end

    initial begin
        int   vcnt;
        int   hs0;
        logic found;
        rst            = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        restart(32'h0);

        #2;
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_if_pc", {32'd0, if_pc}, 64'd0);
        chk("rst_if_instr", {32'd0, if_instr}, 64'd0);
        chk("rst_imem_addr", {32'd0, imem_addr}, 64'd0);

        // Zero-wait memory, decode always ready: one instruction per cycle.
        @(negedge clk);
        #2;
        rst = 1'b0;
        if_ready = 1'b1;
        cyc();
        chk("first_valid", {63'd0, if_valid}, 64'd1);
        chk("first_pc", {32'd0, if_pc}, 64'd0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (if_valid) vcnt++;
        end
        chk("throughput", 64'(vcnt), 64'd20);

        lat_max = 3;
        rand_cycles(3000);

        // Async reset pulse while a request is held without ack.
        cyc();
        if_ready = 1'b1;
        lat_max  = 6;
        found    = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (imem_req && !imem_ack && mem_cnt >= 1) found = 1'b1;
        end
        chk("wait_pending_seen", {63'd0, found}, 64'd1);
        #3;
        rst = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("async_rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("async_rst_imem_req", {63'd0, imem_req}, 64'd0);
        restart(32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        lat_max = 0;
        cyc();
        chk("restart_valid", {63'd0, if_valid}, 64'd1);
        chk("restart_pc", {32'd0, if_pc}, 64'd0);

        lat_max = 3;
        rand_cycles(1500);

        // Drain with no more redirects: the stream must keep flowing.
        cyc();
        if_ready = 1'b1;
        hs0 = n_hs;
        for (int i = 0; i < 40; i++) cyc();
        chk("drain_progress", {63'd0, (n_hs - hs0) >= 10}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
